// File: rtl/vec_queue_sched_if.sv
// Valid/ready beat stream carrying one non-empty stat-vector slot per beat.
interface vec_queue_sched_if #(
  parameter int vec_width_index = 4,
  parameter int vec_width_value = 32,
  parameter int vec_num         = 16
);
  localparam int slot_width = $clog2(vec_num);

  logic                       out_valid;
  logic                       out_ready;
  logic [slot_width-1:0]      out_slot;
  logic [vec_width_index-1:0] out_index;
  logic [vec_width_value-1:0] out_value;

  modport master (
    output out_valid, out_slot, out_index, out_value,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_slot, out_index, out_value,
    output out_ready
  );
endinterface

// File: rtl/vec_queue_sched.sv
// Stat vector queue sequencer: strobes a snapshot, streams every non-empty slot,
// then clears each slot's index once the stream has accepted it.
module vec_queue_sched #(
  parameter int vec_width_index = 4,
  parameter int vec_width_value = 32,
  parameter int vec_num         = 16,
  parameter int period_width    = 24
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               enable,
  input  logic [period_width-1:0]            period,
  input  logic                               snap_req,
  input  logic [vec_width_index*vec_num-1:0] vec_index_in,
  input  logic [vec_width_value*vec_num-1:0] vec_value_in,
  output logic                               chk_out,
  output logic [vec_width_index*vec_num-1:0] clr_out,
  vec_queue_sched_if.master                  out,
  output logic                               busy,
  output logic [15:0]                        overrun_cnt
);

  localparam int slot_width = $clog2(vec_num);
  localparam logic [slot_width-1:0] last_slot = slot_width'(vec_num - 1);

  typedef enum logic [2:0] {IDLE, SNAP, WAIT, SCAN, PRESENT, CLEAR} state_t;

  state_t                             state_q, state_d;
  logic [slot_width-1:0]              slot_q, slot_d;
  logic [period_width-1:0]            tmr_q, period_q, period_eff;
  logic                               run, expire, trigger, load_beat, at_last;
  logic [vec_width_index*vec_num-1:0] clr_d;
  logic [vec_width_index-1:0]         idx_arr [vec_num];
  logic [vec_width_value-1:0]         val_arr [vec_num];
  logic [slot_width-1:0]              beat_slot;
  logic [vec_width_index-1:0]         beat_index;
  logic [vec_width_value-1:0]         beat_value;
  logic [15:0]                        overrun_q;

  for (genvar g = 0; g < vec_num; g++) begin : g_unpack
    assign idx_arr[g] = vec_index_in[g*vec_width_index +: vec_width_index];
    assign val_arr[g] = vec_value_in[g*vec_width_value +: vec_width_value];
  end

  // The live period is used only at count 0; mid-count the latched copy keeps
  // a period change from taking effect before the next wrap.
  assign run        = enable && (period != '0);
  assign period_eff = (tmr_q == '0) ? period : period_q;
  assign expire     = run && (tmr_q == period_eff - period_width'(1));
  assign trigger    = expire || snap_req;
  assign at_last    = (slot_q == last_slot);

  always_comb begin
    // NOTE: every signal written here gets a default first so no path can infer a latch.
    state_d   = state_q;
    slot_d    = slot_q;
    load_beat = 1'b0;
    clr_d     = '0;
    unique case (state_q)
      IDLE:    if (trigger) state_d = SNAP;
      SNAP:    state_d = WAIT;
      WAIT: begin
        state_d = SCAN;
        slot_d  = '0;
      end
      SCAN: begin
        if (idx_arr[slot_q] != '0) begin
          state_d   = PRESENT;
          load_beat = 1'b1;
        end else if (at_last) begin
          state_d = IDLE;
        end else begin
          slot_d = slot_q + slot_width'(1);
        end
      end
      PRESENT: begin
        if (out.out_ready) begin
          state_d = CLEAR;
          for (int s = 0; s < vec_num; s++)
            if (slot_q == slot_width'(s)) clr_d[s*vec_width_index +: vec_width_index] = '1;
        end
      end
      CLEAR: begin
        if (at_last) begin
          state_d = IDLE;
        end else begin
          state_d = SCAN;
          slot_d  = slot_q + slot_width'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: all state below is updated with non-blocking assignments so every
  // register samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      slot_q     <= '0;
      clr_out    <= '0;
      beat_slot  <= '0;
      beat_index <= '0;
      beat_value <= '0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      clr_out <= clr_d;
      if (load_beat) begin
        beat_slot  <= slot_q;
        beat_index <= idx_arr[slot_q];
        beat_value <= val_arr[slot_q];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tmr_q    <= '0;
      period_q <= '0;
    end else if (run) begin
      if (tmr_q == '0) period_q <= period;
      tmr_q <= expire ? '0 : tmr_q + period_width'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      overrun_q <= '0;
    end else if (trigger && (state_q != IDLE) && (overrun_q != 16'hFFFF)) begin
      overrun_q <= overrun_q + 16'd1;
    end
  end

  assign chk_out       = (state_q == SNAP);
  assign busy          = (state_q != IDLE);
  assign overrun_cnt   = overrun_q;
  assign out.out_valid = (state_q == PRESENT);
  assign out.out_slot  = beat_slot;
  assign out.out_index = beat_index;
  assign out.out_value = beat_value;

endmodule
